// File: rtl/mips_ctrl_defs.sv
// Shared encodings for the multi-cycle MIPS main control.
// Pure definitions: no logic, no latency.
// Not applicable: carries no handshake.
package mips_ctrl_defs;

    // State codes are visible on the debug port, so values are fixed.
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Full datapath strobe vector driven by the controller.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode_rom.sv
// Maps the current state to its Moore strobe vector.
// Combinational, zero latency.
// No handshake; FETCH strobes gated by mem_ready are added by the caller.
module ctrl_decode_rom
    import mips_ctrl_defs::*;
(
    input  logic [3:0] state_i,
    output ctrl_t      ctrl_o
);

    // One entry per state; unused codes fall through to all-zero.
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH2;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_B;
                ctrl_o.alu_op        = ALU_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            S_ADDI_WB: begin
                ctrl_o.reg_write = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath, plus retire counter and sticky illegal flag.
// Moore strobes, 3-5 cycles per instruction with memory always ready.
// Stalls in FETCH/MEM_READ/MEM_WRITE while mem_ready is low; mem_ready ignored elsewhere.
module multicycle_control
    import mips_ctrl_defs::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter bit ADDI_EN   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           opcode,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic [1:0]           pc_source,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 mem_to_reg,
    output logic                 reg_dst,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [3:0]           state,
    output logic                 illegal_op,
    output logic [CNT_WIDTH-1:0] retired
);

    state_t                state_q, state_d;
    logic                  illegal_q;
    logic [CNT_WIDTH-1:0]  retired_q;
    logic                  retire;
    logic                  illegal_set;
    ctrl_t                 rom_ctrl;
    ctrl_t                 ctrl;

    ctrl_decode_rom u_rom (
        .state_i (state_q),
        .ctrl_o  (rom_ctrl)
    );

    // Next-state selection and end-of-instruction / illegal-opcode events.
    always_comb begin
        state_d     = S_FETCH;
        retire      = 1'b0;
        illegal_set = 1'b0;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI: begin
                        if (ADDI_EN) state_d = S_ADDI_EXEC;
                        else         illegal_set = 1'b1;
                    end
                    default:      illegal_set = 1'b1;
                endcase
            end
            // Only lw/sw reach here, so anything not lw is a store.
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: begin
                if (mem_ready) retire  = 1'b1;
                else           state_d = S_MEM_WRITE;
            end
            S_EXECUTE:   state_d = S_R_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: retire = 1'b1;
            default:     state_d = S_FETCH;
        endcase
    end

    // State, sticky flag and free-running (wrapping) retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (illegal_set) illegal_q <= 1'b1;
            if (retire)      retired_q <= retired_q + CNT_WIDTH'(1);
        end
    end

    // FETCH loads IR and bumps PC only in the cycle memory delivers; reset silences everything.
    always_comb begin
        ctrl = rom_ctrl;
        if (state_q == S_FETCH && mem_ready) begin
            ctrl.ir_write  = 1'b1;
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_ALU;
        end
        if (reset) ctrl = '0;
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign pc_source     = ctrl.pc_source;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign state         = state_q;
    assign illegal_op    = illegal_q;
    assign retired       = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with hand-computed strobe vectors.
// Each step checks one cycle's state and strobes, then advances one clock.
// Memory stalls are modelled by driving mem_ready low for chosen cycles.
module tb_multicycle_control;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0]  pc_source, alu_src_b, alu_op;
    logic [3:0]  state;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    multicycle_control #(.CNT_WIDTH(32), .ADDI_EN(1'b1)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .state         (state),
        .illegal_op    (illegal_op),
        .retired       (retired)
    );

    // Observed strobes in a fixed order:
    // pc_write, pc_write_cond, pc_source[2], i_or_d, mem_read, mem_write, ir_write,
    // mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[2], alu_op[2]
    wire [15:0] obs_vec = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                           ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op};

    localparam logic [15:0] V_ZERO       = 16'h0000;
    localparam logic [15:0] V_FETCH_STL  = {1'b0,1'b0,2'b00,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00};
    localparam logic [15:0] V_FETCH_RDY  = {1'b1,1'b0,2'b00,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00};
    localparam logic [15:0] V_DECODE     = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00};
    localparam logic [15:0] V_MEM_ADDR   = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00};
    localparam logic [15:0] V_MEM_READ   = {1'b0,1'b0,2'b00,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00};
    localparam logic [15:0] V_MEM_WB     = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00};
    localparam logic [15:0] V_MEM_WRITE  = {1'b0,1'b0,2'b00,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00};
    localparam logic [15:0] V_EXECUTE    = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10};
    localparam logic [15:0] V_R_WB       = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00};
    localparam logic [15:0] V_BRANCH     = {1'b0,1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01};
    localparam logic [15:0] V_JUMP       = {1'b1,1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00};
    localparam logic [15:0] V_ADDI_WB    = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop if the directed sequence somehow stalls.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the current cycle's state and strobes, then move to just after the next edge.
    task automatic step(input string tag, input logic [3:0] exp_state, input logic [15:0] exp_vec);
        #1;
        chk({tag, ".state"}, {28'd0, state}, {28'd0, exp_state});
        chk({tag, ".strobes"}, {16'd0, obs_vec}, {16'd0, exp_vec});
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b1;
        opcode    = 6'b000000;

        // Reset for two cycles; strobes must be silent even with mem_ready high.
        #1;
        chk("rst_strobes_pre", {16'd0, obs_vec}, 32'd0);
        @(posedge clk); #1;
        chk("rst_state", {28'd0, state}, 32'd0);
        chk("rst_strobes", {16'd0, obs_vec}, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_illegal", {31'd0, illegal_op}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // lw: 0,1,2,3,4 then back to 0 with one retirement.
        opcode = 6'b100011;
        step("lw_f", 4'd0, V_FETCH_RDY);
        step("lw_d", 4'd1, V_DECODE);
        step("lw_a", 4'd2, V_MEM_ADDR);
        step("lw_r", 4'd3, V_MEM_READ);
        chk("lw_ret_before", retired, 32'd0);
        step("lw_wb", 4'd4, V_MEM_WB);
        chk("lw_ret", retired, 32'd1);

        // R-type with three FETCH stall cycles: 7 cycles total.
        opcode    = 6'b000000;
        mem_ready = 1'b0;
        step("r_f0", 4'd0, V_FETCH_STL);
        step("r_f1", 4'd0, V_FETCH_STL);
        step("r_f2", 4'd0, V_FETCH_STL);
        mem_ready = 1'b1;
        step("r_f3", 4'd0, V_FETCH_RDY);
        step("r_d",  4'd1, V_DECODE);
        step("r_ex", 4'd6, V_EXECUTE);
        step("r_wb", 4'd7, V_R_WB);
        chk("r_ret", retired, 32'd2);

        // beq then j, 3 cycles each.
        opcode = 6'b000100;
        step("beq_f", 4'd0, V_FETCH_RDY);
        step("beq_d", 4'd1, V_DECODE);
        step("beq_b", 4'd8, V_BRANCH);
        opcode = 6'b000010;
        step("j_f", 4'd0, V_FETCH_RDY);
        step("j_d", 4'd1, V_DECODE);
        step("j_j", 4'd9, V_JUMP);
        chk("bj_ret", retired, 32'd4);

        // Illegal opcode: back to FETCH, flag set, no retirement.
        opcode = 6'b111111;
        step("ill_f", 4'd0, V_FETCH_RDY);
        chk("ill_flag_before", {31'd0, illegal_op}, 32'd0);
        step("ill_d", 4'd1, V_DECODE);
        chk("ill_flag", {31'd0, illegal_op}, 32'd1);
        chk("ill_ret", retired, 32'd4);

        // sw afterwards, store held two cycles waiting for memory.
        opcode = 6'b101011;
        step("sw_f", 4'd0, V_FETCH_RDY);
        step("sw_d", 4'd1, V_DECODE);
        step("sw_a", 4'd2, V_MEM_ADDR);
        mem_ready = 1'b0;
        step("sw_w0", 4'd5, V_MEM_WRITE);
        step("sw_w1", 4'd5, V_MEM_WRITE);
        chk("sw_ret_hold", retired, 32'd4);
        mem_ready = 1'b1;
        step("sw_w2", 4'd5, V_MEM_WRITE);
        chk("sw_ret", retired, 32'd5);
        chk("sw_ill_sticky", {31'd0, illegal_op}, 32'd1);

        // addi with mem_ready low outside FETCH: must not stall.
        opcode = 6'b001000;
        step("addi_f", 4'd0, V_FETCH_RDY);
        mem_ready = 1'b0;
        step("addi_d",  4'd1,  V_DECODE);
        step("addi_ex", 4'd10, V_MEM_ADDR);
        step("addi_wb", 4'd11, V_ADDI_WB);
        chk("addi_ret", retired, 32'd6);

        // Reset while MEM_READ is stalled aborts the load.
        opcode    = 6'b100011;
        mem_ready = 1'b1;
        step("ab_f", 4'd0, V_FETCH_RDY);
        step("ab_d", 4'd1, V_DECODE);
        step("ab_a", 4'd2, V_MEM_ADDR);
        mem_ready = 1'b0;
        step("ab_r", 4'd3, V_MEM_READ);
        reset = 1'b1;
        #1;
        chk("ab_rst_strobes", {16'd0, obs_vec}, {16'd0, V_ZERO});
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("ab_state", {28'd0, state}, 32'd0);
        chk("ab_retired", retired, 32'd0);
        chk("ab_illegal", {31'd0, illegal_op}, 32'd0);
        chk("ab_no_regwrite", {31'd0, reg_write}, 32'd0);
        step("ab_f_after", 4'd0, V_FETCH_STL);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
